// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of the datapath-facing signals of pipeline_hazard_ctrl.
//   slave  : the hazard controller (takes the i_* hazard inputs, drives the o_* controls)
//   master : the datapath/testbench side (drives the i_* inputs, observes the o_* controls)
// Valid/ready note: there is no handshake on this bus. Every i_* is a level that is
// sampled each rising clock edge. Every o_* is combinational from the controller state
// and the current inputs, so it is valid in the same cycle.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             i_ext_int;
  logic             i_int_en;
  logic [4:0]       i_id_rs;
  logic [4:0]       i_id_rt;
  logic             i_id_uses_rt;
  logic             i_ex_lw;
  logic [4:0]       i_ex_rd;
  logic             i_br_taken;
  logic             i_ex_eret;
  logic             i_mem_busy;
  logic             o_we_pc;
  logic             o_we_dec;
  logic             o_we_exec;
  logic             o_we_MemAc;
  logic             o_we_WrBc;
  logic             o_s_rst_dec;
  logic             o_s_rst_exec;
  logic [1:0]       o_pc_sel;
  logic             o_epc_we;
  logic             o_int_ack;
  logic [CNT_W-1:0] o_stall_cnt;

  modport slave (
    input  i_ext_int, i_int_en, i_id_rs, i_id_rt, i_id_uses_rt,
           i_ex_lw, i_ex_rd, i_br_taken, i_ex_eret, i_mem_busy,
    output o_we_pc, o_we_dec, o_we_exec, o_we_MemAc, o_we_WrBc,
           o_s_rst_dec, o_s_rst_exec, o_pc_sel, o_epc_we, o_int_ack, o_stall_cnt
  );

  modport master (
    output i_ext_int, i_int_en, i_id_rs, i_id_rt, i_id_uses_rt,
           i_ex_lw, i_ex_rd, i_br_taken, i_ex_eret, i_mem_busy,
    input  o_we_pc, o_we_dec, o_we_exec, o_we_MemAc, o_we_WrBc,
           o_s_rst_dec, o_s_rst_exec, o_pc_sel, o_epc_we, o_int_ack, o_stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: sequences the 5-stage MIPS pipeline. It drives the per-stage
// write enables and the synchronous flushes, and it selects the next-PC source. It
// resolves load-use stalls, EX-stage branch/jump/eret redirects, data-memory wait
// states and external interrupts.
// Ports:
//   i_clk        clock, all state on the rising edge
//   i_a_rst_n    asynchronous active-low reset
//   bus          pipeline_hazard_ctrl_if.slave carrying the hazard inputs and pipeline controls
//   o_fsm_state  current FSM state (0 RUN, 1 DRAIN, 2 VECTOR) for observation
// Parameters:
//   DRAIN_CYCLES  cycles spent in DRAIN before vectoring, legal range 1..15
//   CNT_W         width of the saturating stall counter (must match the interface)
module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic                         i_clk,
  input  logic                         i_a_rst_n,
  pipeline_hazard_ctrl_if.slave        bus,
  output logic [1:0]                   o_fsm_state
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_VECTOR = 2'd2
  } state_t;

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  state_t           state_q, state_nxt;
  logic [3:0]       cnt_q, cnt_nxt;
  logic [CNT_W-1:0] stall_q;
  logic             load_use;

  logic             we_pc, we_dec, we_exec, we_mem, we_wb;
  logic             s_rst_dec, s_rst_exec, epc_we, int_ack;
  logic [1:0]       pc_sel;

  // Register $0 never carries a real dependency, so a load into it cannot cause a stall.
  assign load_use = bus.i_ex_lw && (bus.i_ex_rd != 5'd0) &&
                    ((bus.i_ex_rd == bus.i_id_rs) ||
                     (bus.i_id_uses_rt && (bus.i_ex_rd == bus.i_id_rt)));

  always_ff @(posedge i_clk or negedge i_a_rst_n) begin
    if (!i_a_rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = cnt_q;
    we_pc      = 1'b1;
    we_dec     = 1'b1;
    we_exec    = 1'b1;
    we_mem     = 1'b1;
    we_wb      = 1'b1;
    s_rst_dec  = 1'b0;
    s_rst_exec = 1'b0;
    pc_sel     = 2'd0;
    epc_we     = 1'b0;
    int_ack    = 1'b0;

    case (state_q)
      ST_RUN: begin
        cnt_nxt = 4'd0;
        if (bus.i_mem_busy) begin
          // The whole pipeline freezes. An interrupt raised now is retried next cycle.
          {we_pc, we_dec, we_exec, we_mem, we_wb} = 5'b00000;
        end else if (bus.i_br_taken || bus.i_ex_eret) begin
          // Redirect: both younger wrong-path instructions are killed.
          // A redirect makes the load-use check irrelevant.
          pc_sel     = bus.i_ex_eret ? 2'd3 : 2'd1;
          s_rst_dec  = 1'b1;
          s_rst_exec = 1'b1;
        end else begin
          if (bus.i_ext_int && bus.i_int_en) state_nxt = ST_DRAIN;
          if (load_use) begin
            we_pc      = 1'b0;
            we_dec     = 1'b0;
            s_rst_exec = 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        // The front end is held and bubbles enter EX while MEM/WB retire older work.
        // The request is already latched by being in this state.
        if (bus.i_mem_busy) begin
          {we_pc, we_dec, we_exec, we_mem, we_wb} = 5'b00000;
        end else begin
          we_pc      = 1'b0;
          we_dec     = 1'b0;
          s_rst_exec = 1'b1;
          if (cnt_q == DRAIN_LAST) state_nxt = ST_VECTOR;
          cnt_nxt = 4'(cnt_q + 4'd1);
        end
      end

      ST_VECTOR: begin
        if (bus.i_mem_busy) begin
          {we_pc, we_dec, we_exec, we_mem, we_wb} = 5'b00000;
        end else begin
          pc_sel     = 2'd2;
          epc_we     = 1'b1;
          int_ack    = 1'b1;
          s_rst_dec  = 1'b1;
          s_rst_exec = 1'b1;
          cnt_nxt    = 4'd0;
          state_nxt  = ST_RUN;
        end
      end

      default: begin
        state_nxt = ST_RUN;
        cnt_nxt   = 4'd0;
      end
    endcase

    // While reset is held, the pipeline sees the plain RUN defaults whatever the inputs do.
    if (!i_a_rst_n) begin
      {we_pc, we_dec, we_exec, we_mem, we_wb} = 5'b11111;
      s_rst_dec  = 1'b0;
      s_rst_exec = 1'b0;
      pc_sel     = 2'd0;
      epc_we     = 1'b0;
      int_ack    = 1'b0;
    end
  end

  // Count the cycles with the PC frozen, and hold at all-ones instead of wrapping.
  always_ff @(posedge i_clk or negedge i_a_rst_n) begin
    if (!i_a_rst_n) begin
      stall_q <= '0;
    end else if (!we_pc && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.o_we_pc      = we_pc;
  assign bus.o_we_dec     = we_dec;
  assign bus.o_we_exec    = we_exec;
  assign bus.o_we_MemAc   = we_mem;
  assign bus.o_we_WrBc    = we_wb;
  assign bus.o_s_rst_dec  = s_rst_dec;
  assign bus.o_s_rst_exec = s_rst_exec;
  assign bus.o_pc_sel     = pc_sel;
  assign bus.o_epc_we     = epc_we;
  assign bus.o_int_ack    = int_ack;
  assign bus.o_stall_cnt  = stall_q;
  assign o_fsm_state      = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int DRAIN_CYCLES = 3;
  localparam int CNT_W        = 5;
  localparam int STALL_MAX    = (1 << CNT_W) - 1;

  logic       clk;
  logic       rst_n;
  logic [1:0] fsm_state;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
    .i_clk       (clk),
    .i_a_rst_n   (rst_n),
    .bus         (bus),
    .o_fsm_state (fsm_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endfunction

  // ---------------- behavioural model ----------------
  // Observable output bundle: we = {pc, dec, exec, MemAc, WrBc}
  typedef struct packed {
    logic [4:0] we;
    logic       s_dec;
    logic       s_exec;
    logic [1:0] pc_sel;
    logic       epc_we;
    logic       ack;
  } outs_t;

  int m_drain_left;  // DRAIN cycles still owed before the vector cycle (0 = not draining)
  bit m_vector;      // vector cycle pending
  int m_stall;       // PC-frozen cycles so far, saturating

  function automatic void model_reset();
    m_drain_left = 0;
    m_vector     = 1'b0;
    m_stall      = 0;
  endfunction

  function automatic bit hazard();
    return bus.i_ex_lw && (bus.i_ex_rd != 0) &&
           ((bus.i_ex_rd == bus.i_id_rs) || (bus.i_id_uses_rt && (bus.i_ex_rd == bus.i_id_rt)));
  endfunction

  function automatic outs_t exp_outs();
    outs_t o;
    o = '{we: 5'b11111, s_dec: 1'b0, s_exec: 1'b0, pc_sel: 2'd0, epc_we: 1'b0, ack: 1'b0};
    if (!rst_n) return o;
    if (bus.i_mem_busy) begin
      o.we = 5'b00000;
    end else if (m_vector) begin
      o.pc_sel = 2'd2; o.s_dec = 1'b1; o.s_exec = 1'b1; o.epc_we = 1'b1; o.ack = 1'b1;
    end else if (m_drain_left > 0) begin
      o.we = 5'b00111; o.s_exec = 1'b1;
    end else if (bus.i_br_taken || bus.i_ex_eret) begin
      o.pc_sel = bus.i_ex_eret ? 2'd3 : 2'd1; o.s_dec = 1'b1; o.s_exec = 1'b1;
    end else if (hazard()) begin
      o.we = 5'b00111; o.s_exec = 1'b1;
    end
    return o;
  endfunction

  function automatic logic [1:0] exp_state();
    if (m_vector) return 2'd2;
    if (m_drain_left > 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic outs_t dut_outs();
    outs_t o;
    o.we     = {bus.o_we_pc, bus.o_we_dec, bus.o_we_exec, bus.o_we_MemAc, bus.o_we_WrBc};
    o.s_dec  = bus.o_s_rst_dec;
    o.s_exec = bus.o_s_rst_exec;
    o.pc_sel = bus.o_pc_sel;
    o.epc_we = bus.o_epc_we;
    o.ack    = bus.o_int_ack;
    return o;
  endfunction

  // Model advance at each rising edge, using the inputs of the cycle just ending.
  always @(posedge clk) begin
    outs_t e;
    if (!rst_n) begin
      model_reset();
    end else begin
      e = exp_outs();
      if (!e.we[4] && m_stall < STALL_MAX) m_stall++;
      if (!bus.i_mem_busy) begin
        if (m_vector) begin
          m_vector = 1'b0;
        end else if (m_drain_left > 0) begin
          m_drain_left--;
          if (m_drain_left == 0) m_vector = 1'b1;
        end else if (!bus.i_br_taken && !bus.i_ex_eret && bus.i_ext_int && bus.i_int_en) begin
          m_drain_left = DRAIN_CYCLES;
        end
      end
    end
  end

  // ---------------- compare process (scoreboard) ----------------
  always @(negedge clk) begin
    if (!rst_n) model_reset();
    chk("outputs",   32'(dut_outs()),        32'(exp_outs()));
    chk("stall_cnt", 32'(bus.o_stall_cnt),   32'(m_stall));
    chk("fsm_state", 32'(fsm_state),         32'(exp_state()));
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input bit busy, input bit br, input bit eret, input bit ext, input bit en,
                        input bit lw, input int rd, input int rs, input int rt, input bit uses);
    bus.i_mem_busy   = busy;
    bus.i_br_taken   = br;
    bus.i_ex_eret    = eret;
    bus.i_ext_int    = ext;
    bus.i_int_en     = en;
    bus.i_ex_lw      = lw;
    bus.i_ex_rd      = 5'(rd);
    bus.i_id_rs      = 5'(rs);
    bus.i_id_rt      = 5'(rt);
    bus.i_id_uses_rt = uses;
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic mid_cyc();
    @(negedge clk); #1;
  endtask

  task automatic idle();
    next_cyc(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); mid_cyc();
  endtask

  // Idle cycles while tallying the DRAIN cycles and interrupt acknowledges that are seen.
  task automatic idle_count(input int n, inout int drains, inout int acks);
    for (int k = 0; k < n; k++) begin
      idle();
      if (fsm_state == 2'd1) drains++;
      if (bus.o_int_ack) acks++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base, drains, acks;
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    set_in(1, 1, 0, 1, 1, 1, 8, 8, 0, 0);   // reset must mask whatever the inputs say
    mid_cyc();
    chk("reset_we_pc",  32'(bus.o_we_pc),     32'd1);
    chk("reset_pc_sel", 32'(bus.o_pc_sel),    32'd0);
    chk("reset_stall",  32'(bus.o_stall_cnt), 32'd0);
    next_cyc(); rst_n = 1'b1; set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); mid_cyc();

    // lw $t0 in EX, add reads $t0 in decode: one stall cycle.
    next_cyc(); set_in(0, 0, 0, 0, 0, 1, 8, 8, 9, 1); mid_cyc();
    chk("lu_we", 32'({bus.o_we_pc, bus.o_we_dec, bus.o_s_rst_exec}), 32'b001);
    idle();
    chk("lu_stall_cnt", 32'(bus.o_stall_cnt), 32'd1);

    // lw into $0 with decode reading $0: no stall.
    next_cyc(); set_in(0, 0, 0, 0, 0, 1, 0, 0, 0, 1); mid_cyc();
    chk("lw_r0_we_pc", 32'(bus.o_we_pc), 32'd1);

    // A branch in the same cycle as a load-use hazard: the redirect wins.
    next_cyc(); set_in(0, 1, 0, 0, 0, 1, 8, 0, 8, 1); mid_cyc();
    chk("br_lu", 32'({bus.o_pc_sel, bus.o_s_rst_dec, bus.o_s_rst_exec, bus.o_we_pc}), 32'b01111);

    // eret selects EPC.
    next_cyc(); set_in(0, 0, 1, 0, 0, 0, 0, 0, 0, 0); mid_cyc();
    chk("eret_pc_sel", 32'(bus.o_pc_sel), 32'd3);

    // Interrupt pulsed for one cycle: 3 DRAIN cycles, then one VECTOR cycle.
    next_cyc(); set_in(0, 0, 0, 1, 1, 0, 0, 0, 0, 0); mid_cyc();
    base = int'(bus.o_stall_cnt); drains = 0; acks = 0;
    for (int k = 0; k < 6; k++) begin
      idle();
      if (fsm_state == 2'd1) drains++;
      if (bus.o_int_ack) begin
        acks++;
        chk("vec_pc_sel_epc", 32'({bus.o_pc_sel, bus.o_epc_we}), 32'b101);
      end
    end
    chk("int_drain_cycles", 32'(drains), 32'd3);
    chk("int_ack_count",    32'(acks),   32'd1);
    chk("int_stall_delta",  32'(int'(bus.o_stall_cnt) - base), 32'd3);

    // Two busy cycles mid-DRAIN stretch DRAIN to 5 cycles.
    next_cyc(); set_in(0, 0, 0, 1, 1, 0, 0, 0, 0, 0); mid_cyc();
    base = int'(bus.o_stall_cnt); drains = 0; acks = 0;
    idle_count(1, drains, acks);
    for (int k = 0; k < 2; k++) begin
      next_cyc(); set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); mid_cyc();
      if (fsm_state == 2'd1) drains++;
      chk("drain_busy_we", 32'({bus.o_we_pc, bus.o_we_dec, bus.o_we_exec, bus.o_we_MemAc, bus.o_we_WrBc}), 32'd0);
    end
    idle_count(6, drains, acks);
    chk("busy_drain_cycles", 32'(drains), 32'd5);
    chk("busy_ack_count",    32'(acks),   32'd1);
    chk("busy_stall_delta",  32'(int'(bus.o_stall_cnt) - base), 32'd5);

    // Interrupt request refused while the memory is busy.
    next_cyc(); set_in(1, 0, 0, 1, 1, 0, 0, 0, 0, 0); mid_cyc();
    idle();
    chk("busy_blocks_int", 32'(fsm_state), 32'd0);

    // Reset asserted in the second DRAIN cycle: RUN defaults at once, no acknowledge later.
    next_cyc(); set_in(0, 0, 0, 1, 1, 0, 0, 0, 0, 0); mid_cyc();
    idle();
    next_cyc(); rst_n = 1'b0; set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); mid_cyc();
    chk("rst_drain_state", 32'(fsm_state), 32'd0);
    chk("rst_drain_we",    32'({bus.o_we_pc, bus.o_we_dec, bus.o_s_rst_exec, bus.o_int_ack}), 32'b1100);
    next_cyc(); rst_n = 1'b1; mid_cyc();
    drains = 0; acks = 0;
    idle_count(6, drains, acks);
    chk("rst_no_ack", 32'(acks), 32'd0);

    // Random traffic, with occasional reset pulses.
    for (int k = 0; k < 3000; k++) begin
      next_cyc();
      rst_n = ($urandom_range(0, 199) != 0);
      set_in($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 3,
             $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 40,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             $urandom_range(0, 1) == 1);
      mid_cyc();
    end
    next_cyc(); rst_n = 1'b1; set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); mid_cyc();

    // Stall counter saturation.
    for (int k = 0; k < STALL_MAX + 8; k++) begin
      next_cyc(); set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); mid_cyc();
    end
    idle();
    chk("stall_saturate", 32'(bus.o_stall_cnt), 32'(STALL_MAX));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
